// File: rtl/tpu_weight_buffer_ring_if.sv
// Bundle for the weight buffer ring. It carries the loader write port, the
// per-bank read ports, the set ownership handshakes and the status/error
// outputs. The master modport is the loader/array side and the slave modport
// is the buffer.
interface tpu_weight_buffer_ring_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int WEIGHT_W   = 2,
  parameter int MAX_K      = 256,
  parameter int NUM_BANKS  = 8,
  parameter int NUM_SETS   = 3,
  parameter int ADDR_WIDTH = 16
);
  localparam int ROW_W = ARRAY_SIZE * WEIGHT_W;
  localparam int RA_W  = $clog2(MAX_K / NUM_BANKS);
  localparam int SET_W = $clog2(NUM_SETS);
  localparam int CNT_W = $clog2(NUM_SETS + 1);

  logic                           flush;
  logic                           wr_valid;
  logic                           wr_ready;
  logic [ADDR_WIDTH-1:0]          wr_addr;
  logic [ROW_W-1:0]               wr_data;
  logic                           wr_commit;
  logic [NUM_BANKS-1:0]           rd_en;
  logic [NUM_BANKS*RA_W-1:0]      rd_addr;
  logic [NUM_BANKS*ROW_W-1:0]     rd_data;
  logic [NUM_BANKS-1:0]           rd_valid;
  logic                           rd_release;
  logic                           rd_set_valid;
  logic [CNT_W-1:0]               set_count;
  logic [SET_W-1:0]               wr_set;
  logic [SET_W-1:0]               rd_set;
  logic                           err_overflow;
  logic                           err_underflow;
  logic                           err_addr;

  modport master (
    output flush, wr_valid, wr_addr, wr_data, wr_commit,
           rd_en, rd_addr, rd_release,
    input  wr_ready, rd_data, rd_valid, rd_set_valid, set_count,
           wr_set, rd_set, err_overflow, err_underflow, err_addr
  );

  modport slave (
    input  flush, wr_valid, wr_addr, wr_data, wr_commit,
           rd_en, rd_addr, rd_release,
    output wr_ready, rd_data, rd_valid, rd_set_valid, set_count,
           wr_set, rd_set, err_overflow, err_underflow, err_addr
  );
endinterface

// File: rtl/tpu_weight_buffer_ring.sv
// Ring of NUM_SETS banked weight sets. The loader fills set wr_set while the
// systolic array reads committed set rd_set through NUM_BANKS independent
// 1-cycle read ports. Commit hands a filled set to the reader and release
// returns it to the loader. Because the write side stalls when the ring is
// full, the written and read sets never coincide, so no arbitration is needed.
module tpu_weight_buffer_ring #(
  parameter int ARRAY_SIZE = 8,
  parameter int WEIGHT_W   = 2,
  parameter int MAX_K      = 256,
  parameter int NUM_BANKS  = 8,
  parameter int NUM_SETS   = 3,
  parameter int ADDR_WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  tpu_weight_buffer_ring_if.slave bus
);
  localparam int ROW_W  = ARRAY_SIZE * WEIGHT_W;
  localparam int ROWS   = MAX_K / NUM_BANKS;
  localparam int RA_W   = $clog2(ROWS);
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int K_W    = $clog2(MAX_K);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int CNT_W  = $clog2(NUM_SETS + 1);

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SETS);

  // Ring pointer increment with wrap at the last set.
  function automatic logic [SET_W-1:0] next_set(input logic [SET_W-1:0] ptr);
    return (ptr == LAST_SET) ? '0 : ptr + SET_W'(1);
  endfunction

  logic [SET_W-1:0]  wr_set_q;
  logic [SET_W-1:0]  rd_set_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_next;
  logic              err_overflow_q;
  logic              err_underflow_q;
  logic              err_addr_q;

  logic              wr_ready;
  logic              rd_set_valid;
  logic              addr_in_range;
  logic              wr_fire;
  logic              addr_err;
  logic              release_ok;
  logic              commit_ok;
  logic [BANK_W-1:0] wr_bank;
  logic [RA_W-1:0]   wr_row;

  // Bank is the low address bits so consecutive rows spread across banks.
  assign wr_bank       = bus.wr_addr[BANK_W-1:0];
  assign wr_row        = bus.wr_addr[K_W-1:BANK_W];
  assign addr_in_range = (bus.wr_addr[ADDR_WIDTH-1:K_W] == '0);

  assign wr_ready      = (count_q != FULL_CNT);
  assign rd_set_valid  = (count_q != '0);
  assign wr_fire       = bus.wr_valid && wr_ready && addr_in_range;
  // A stalled write is ordinary backpressure, so only accepted writes can
  // flag a bad address.
  assign addr_err      = bus.wr_valid && wr_ready && !addr_in_range;
  assign release_ok    = bus.rd_release && rd_set_valid;
  // Release frees a slot in the same cycle, so a commit at full ring is
  // legal when paired with a legal release.
  assign commit_ok     = bus.wr_commit && (wr_ready || release_ok);

  // Occupancy update from the qualified commit/release pair.
  always_comb begin
    count_next = count_q;
    case ({commit_ok, release_ok})
      2'b10:   count_next = count_q + CNT_W'(1);
      2'b01:   count_next = count_q - CNT_W'(1);
      default: count_next = count_q;
    endcase
  end

  // Set ownership pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_set_q        <= '0;
      rd_set_q        <= '0;
      count_q         <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_addr_q      <= 1'b0;
    end else if (bus.flush) begin
      wr_set_q        <= '0;
      rd_set_q        <= '0;
      count_q         <= '0;
      err_overflow_q  <= 1'b0;
      err_underflow_q <= 1'b0;
      err_addr_q      <= 1'b0;
    end else begin
      if (commit_ok)  wr_set_q <= next_set(wr_set_q);
      if (release_ok) rd_set_q <= next_set(rd_set_q);
      count_q         <= count_next;
      err_overflow_q  <= err_overflow_q  | (bus.wr_commit && !commit_ok);
      err_underflow_q <= err_underflow_q | (bus.rd_release && !release_ok);
      err_addr_q      <= err_addr_q      | addr_err;
    end
  end

  assign bus.wr_ready      = wr_ready;
  assign bus.rd_set_valid  = rd_set_valid;
  assign bus.set_count     = count_q;
  assign bus.wr_set        = wr_set_q;
  assign bus.rd_set        = rd_set_q;
  assign bus.err_overflow  = err_overflow_q;
  assign bus.err_underflow = err_underflow_q;
  assign bus.err_addr      = err_addr_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [ROW_W-1:0] mem [NUM_SETS][ROWS];
    logic [RA_W-1:0]  rd_row_p0;
    logic             rd_issue_p0;
    logic             rd_vld_p1;
    logic [ROW_W-1:0] rd_data_p1;

    assign rd_row_p0   = bus.rd_addr[b*RA_W +: RA_W];
    assign rd_issue_p0 = bus.rd_en[b] && rd_set_valid && !bus.flush;

    // Bank storage write port; contents survive reset and flush.
    always_ff @(posedge clk) begin
      if (wr_fire && (wr_bank == BANK_W'(b))) begin
        mem[wr_set_q][wr_row] <= bus.wr_data;
      end
    end

    // Issue -> p1: registered read of the current read set, zero when idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_vld_p1  <= 1'b0;
        rd_data_p1 <= '0;
      end else if (rd_issue_p0) begin
        rd_vld_p1  <= 1'b1;
        rd_data_p1 <= mem[rd_set_q][rd_row_p0];
      end else begin
        rd_vld_p1  <= 1'b0;
        rd_data_p1 <= '0;
      end
    end

    assign bus.rd_valid[b]                 = rd_vld_p1;
    assign bus.rd_data[b*ROW_W +: ROW_W]   = rd_data_p1;
  end

endmodule
